// File: rtl/core_btb_pkg.sv
// rtl/core_btb_pkg.sv - branch type and counter encodings shared by the BTB files
package core_btb_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JUMP = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_type_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/core_btb_if.sv
// rtl/core_btb_if.sv - fetch lookup, RAS drive and training signals of the BTB
interface core_btb_if;
    logic        fetch_valid;
    logic [31:0] pc_in;
    logic [31:0] ras_addr_in;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic [1:0]  upd_type;
    logic        upd_taken;
    logic        inv_all;
    logic        btb_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        en_call_out;
    logic        en_ret_out;
    logic [31:0] ret_addr_out;

    modport master (
        output fetch_valid, pc_in, ras_addr_in,
        output upd_valid, upd_pc, upd_target, upd_type, upd_taken, inv_all,
        input  btb_hit, pred_taken, pred_target, en_call_out, en_ret_out, ret_addr_out
    );

    modport slave (
        input  fetch_valid, pc_in, ras_addr_in,
        input  upd_valid, upd_pc, upd_target, upd_type, upd_taken, inv_all,
        output btb_hit, pred_taken, pred_target, en_call_out, en_ret_out, ret_addr_out
    );
endinterface

// File: rtl/core_btb_sat_ctr.sv
// rtl/core_btb_sat_ctr.sv - 2-bit saturating direction counter next state
module core_btb_sat_ctr
    import core_btb_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
        end else if (ctr_i != CTR_SNT) begin
            ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/core_btb.sv
// rtl/core_btb.sv - direct-mapped fetch BTB with RAS call/return drive
// Optional CORE_BTB_FWD_EN: same-cycle update is forwarded into the lookup.
module core_btb
    import core_btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 26
) (
    input  logic       clk,
    input  logic       rst,
    core_btb_if.slave  bus
);

    localparam int IDX_W = idx_width(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [29:0]        target_q [ENTRIES];
    logic [1:0]         type_q   [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             upd_hit, wr_en;
    logic [1:0]       ctr_upd, ctr_d;
    logic             unused_pc_bits;

    assign f_idx = bus.pc_in[IDX_W+1:2];
    assign f_tag = bus.pc_in[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = bus.upd_pc[IDX_W+1:2];
    assign u_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_pc_bits = ^{bus.upd_pc[1:0], bus.upd_target[1:0]};

    assign upd_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    core_btb_sat_ctr u_sat_ctr (
        .ctr_i   (ctr_q[u_idx]),
        .taken_i (bus.upd_taken),
        .ctr_o   (ctr_upd)
    );

    // A not-taken miss never allocates; fresh conds start weakly taken.
    always_comb begin
        wr_en = bus.upd_valid && (upd_hit || bus.upd_taken);
        ctr_d = (bus.upd_type == BR_COND) ? CTR_WT : CTR_ST;
        if (upd_hit) ctr_d = ctr_upd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                type_q[i]   <= BR_COND;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (bus.inv_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= bus.upd_target[31:2];
            type_q[u_idx]   <= bus.upd_type;
            ctr_q[u_idx]    <= ctr_d;
        end
    end

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [29:0]      rd_target;
    logic [1:0]       rd_type;
    logic [1:0]       rd_ctr;

    always_comb begin
        rd_valid  = valid_q[f_idx];
        rd_tag    = tag_q[f_idx];
        rd_target = target_q[f_idx];
        rd_type   = type_q[f_idx];
        rd_ctr    = ctr_q[f_idx];
`ifdef CORE_BTB_FWD_EN
        if (wr_en && (u_idx == f_idx)) begin
            rd_valid  = 1'b1;
            rd_tag    = u_tag;
            rd_target = bus.upd_target[31:2];
            rd_type   = bus.upd_type;
            rd_ctr    = ctr_d;
        end
        if (bus.inv_all) rd_valid = 1'b0;
`endif
    end

    logic        hit, taken;
    logic [31:0] seq_pc;

    assign hit    = bus.fetch_valid && rd_valid && (rd_tag == f_tag);
    assign taken  = hit && ((rd_type != BR_COND) || rd_ctr[1]);
    assign seq_pc = bus.pc_in + 32'd4;

    assign bus.btb_hit      = hit;
    assign bus.pred_taken   = taken;
    assign bus.en_call_out  = hit && (rd_type == BR_CALL);
    assign bus.en_ret_out   = hit && (rd_type == BR_RET);
    assign bus.ret_addr_out = seq_pc;
    assign bus.pred_target  = !taken               ? seq_pc :
                              (rd_type == BR_RET)  ? bus.ras_addr_in :
                                                     {rd_target, 2'b00};

endmodule

// File: tb/tb_core_btb.sv
// tb/tb_core_btb.sv - directed self-checking bench for core_btb
module tb_core_btb;
    import core_btb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_btb_if btb_if();

    core_btb u_dut (
        .clk (clk),
        .rst (rst),
        .bus (btb_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [1:0] typ, input logic tk);
        @(negedge clk);
        btb_if.upd_valid  = 1'b1;
        btb_if.upd_pc     = pc;
        btb_if.upd_target = tgt;
        btb_if.upd_type   = typ;
        btb_if.upd_taken  = tk;
        @(negedge clk);
        btb_if.upd_valid  = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] ras);
        btb_if.fetch_valid = 1'b1;
        btb_if.pc_in       = pc;
        btb_if.ras_addr_in = ras;
        #1;
    endtask

    initial begin
        rst                = 1'b0;
        btb_if.fetch_valid = 1'b1;
        btb_if.pc_in       = 32'h0000_0100;
        btb_if.ras_addr_in = 32'h0;
        btb_if.upd_valid   = 1'b0;
        btb_if.upd_pc      = 32'h0;
        btb_if.upd_target  = 32'h0;
        btb_if.upd_type    = BR_COND;
        btb_if.upd_taken   = 1'b0;
        btb_if.inv_all     = 1'b0;
        #1;
        check("rst_hit",    btb_if.btb_hit,      0);
        check("rst_ptaken", btb_if.pred_taken,   0);
        check("rst_target", btb_if.pred_target,  32'h104);
        check("rst_ret",    btb_if.ret_addr_out, 32'h104);
        check("rst_call",   btb_if.en_call_out,  0);
        check("rst_pop",    btb_if.en_ret_out,   0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        lookup(32'h100, 32'h0);
        check("post_rst_hit", btb_if.btb_hit,     0);
        check("post_rst_tgt", btb_if.pred_target, 32'h104);

        upd(32'h100, 32'h2000, BR_CALL, 1'b1);
        lookup(32'h100, 32'h0);
        check("call_hit",  btb_if.btb_hit,      1);
        check("call_pt",   btb_if.pred_taken,   1);
        check("call_tgt",  btb_if.pred_target,  32'h2000);
        check("call_push", btb_if.en_call_out,  1);
        check("call_pop",  btb_if.en_ret_out,   0);
        check("call_ra",   btb_if.ret_addr_out, 32'h104);

        upd(32'h2040, 32'h0, BR_RET, 1'b1);
        lookup(32'h2040, 32'h104);
        check("ret_hit",  btb_if.btb_hit,     1);
        check("ret_pop",  btb_if.en_ret_out,  1);
        check("ret_push", btb_if.en_call_out, 0);
        check("ret_tgt",  btb_if.pred_target, 32'h104);

        // counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11(x5) -> 10 -> 01
        upd(32'h300, 32'h3000, BR_COND, 1'b1);
        lookup(32'h300, 32'h0);
        check("cond_alloc_pt",  btb_if.pred_taken,  1);
        check("cond_alloc_tgt", btb_if.pred_target, 32'h3000);
        upd(32'h300, 32'h3000, BR_COND, 1'b0);
        lookup(32'h300, 32'h0);
        check("nt1_pt",  btb_if.pred_taken,  0);
        check("nt1_tgt", btb_if.pred_target, 32'h304);
        upd(32'h300, 32'h3000, BR_COND, 1'b0);
        lookup(32'h300, 32'h0);
        check("nt2_pt", btb_if.pred_taken, 0);
        upd(32'h300, 32'h3000, BR_COND, 1'b0);
        lookup(32'h300, 32'h0);
        check("nt3_pt", btb_if.pred_taken, 0);
        upd(32'h300, 32'h3000, BR_COND, 1'b1);
        lookup(32'h300, 32'h0);
        check("t1_pt", btb_if.pred_taken, 0);
        upd(32'h300, 32'h3000, BR_COND, 1'b1);
        lookup(32'h300, 32'h0);
        check("t2_pt", btb_if.pred_taken, 1);
        for (int i = 0; i < 5; i++) upd(32'h300, 32'h3000, BR_COND, 1'b1);
        lookup(32'h300, 32'h0);
        check("t5_pt", btb_if.pred_taken, 1);
        upd(32'h300, 32'h3000, BR_COND, 1'b0);
        lookup(32'h300, 32'h0);
        check("sat_nt1_pt", btb_if.pred_taken, 1);
        upd(32'h300, 32'h3000, BR_COND, 1'b0);
        lookup(32'h300, 32'h0);
        check("sat_nt2_pt", btb_if.pred_taken, 0);

        upd(32'h600, 32'h6000, BR_JUMP, 1'b0);
        lookup(32'h600, 32'h0);
        check("nt_miss_noalloc", btb_if.btb_hit, 0);
        lookup(32'h300, 32'h0);
        check("nt_miss_keep", btb_if.btb_hit, 1);

        upd(32'h100, 32'h2000, BR_CALL, 1'b1);
        upd(32'h140, 32'h4000, BR_JUMP, 1'b1);
        lookup(32'h100, 32'h0);
        check("alias_old_miss", btb_if.btb_hit, 0);
        lookup(32'h140, 32'h0);
        check("alias_new_hit", btb_if.btb_hit,     1);
        check("alias_new_tgt", btb_if.pred_target, 32'h4000);

        btb_if.fetch_valid = 1'b0;
        #1;
        check("fv_gate_hit", btb_if.btb_hit,     0);
        check("fv_gate_tgt", btb_if.pred_target, 32'h144);

        @(negedge clk);
        btb_if.inv_all    = 1'b1;
        btb_if.upd_valid  = 1'b1;
        btb_if.upd_pc     = 32'h700;
        btb_if.upd_target = 32'h7000;
        btb_if.upd_type   = BR_JUMP;
        btb_if.upd_taken  = 1'b1;
        @(negedge clk);
        btb_if.inv_all    = 1'b0;
        btb_if.upd_valid  = 1'b0;
        lookup(32'h140, 32'h0);
        check("inv_old_miss", btb_if.btb_hit, 0);
        lookup(32'h700, 32'h0);
        check("inv_upd_miss", btb_if.btb_hit, 0);

        lookup(32'hFFFF_FFFC, 32'h0);
        check("wrap_ra",  btb_if.ret_addr_out, 32'h0);
        check("wrap_tgt", btb_if.pred_target,  32'h0);

        @(negedge clk);
        btb_if.upd_valid  = 1'b1;
        btb_if.upd_pc     = 32'h500;
        btb_if.upd_target = 32'h5000;
        btb_if.upd_type   = BR_JUMP;
        btb_if.upd_taken  = 1'b1;
        lookup(32'h500, 32'h0);
`ifdef CORE_BTB_FWD_EN
        check("same_cyc_hit", btb_if.btb_hit,     1);
        check("same_cyc_tgt", btb_if.pred_target, 32'h5000);
`else
        check("same_cyc_hit", btb_if.btb_hit,     0);
        check("same_cyc_tgt", btb_if.pred_target, 32'h504);
`endif
        @(negedge clk);
        btb_if.upd_valid = 1'b0;
        #1;
        check("next_cyc_hit", btb_if.btb_hit,     1);
        check("next_cyc_tgt", btb_if.pred_target, 32'h5000);

        @(negedge clk);
        btb_if.upd_valid  = 1'b1;
        btb_if.upd_pc     = 32'h900;
        btb_if.upd_target = 32'h9000;
        btb_if.upd_type   = BR_JUMP;
        btb_if.upd_taken  = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        btb_if.upd_valid = 1'b0;
        lookup(32'h900, 32'h0);
        check("rst_mid_upd_miss", btb_if.btb_hit, 0);
        lookup(32'h500, 32'h0);
        check("rst_clears_old", btb_if.btb_hit, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_btb.md
# core_btb

Fetch-stage branch target buffer: direct-mapped, 16 entries, each holding a tag, a 30-bit target, a 2-bit branch type and a 2-bit saturating direction counter. Looked up combinationally with the fetch PC. Produces the next-PC prediction and drives the call/return enables and return address into the return address stack, which sits directly downstream. Trained by one update port from the decode/execute resolution logic.

## Interface
- ENTRIES, 16: number of entries, power of two; index = pc[IDX_W+1:2], IDX_W = log2(ENTRIES).
- TAG_W, 26: tag width; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; the default uses all remaining PC bits.

- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  pc_in is a real fetch this cycle.
- pc_in  in  32  fetch PC, word aligned.
- ras_addr_in  in  32  top-of-stack address from the RAS.
- upd_valid  in  1  training event this cycle.
- upd_pc  in  32  PC of the resolved control instruction.
- upd_target  in  32  resolved target.
- upd_type  in  2  00 cond branch, 01 jump, 10 call, 11 return.
- upd_taken  in  1  resolved direction.
- inv_all  in  1  synchronous invalidate of every entry.
- btb_hit  out  1  valid entry with matching tag, gated by fetch_valid.
- pred_taken  out  1  prediction is redirect.
- pred_target  out  32  next fetch PC.
- en_call_out  out  1  push request to RAS.
- en_ret_out  out  1  pop request to RAS.
- ret_addr_out  out  32  pc_in + 4, for the RAS push.

## Operation
- **Lookup (combinational):**
  - btb_hit = fetch_valid & valid[idx] & (tag[idx] == pc_in tag).
  - pred_taken = btb_hit & (type != 00 | ctr[idx][1]).
  - pred_target selection:
    - not pred_taken: pc_in + 4.
    - type 11: ras_addr_in.
    - otherwise: {target[idx], 2'b00}.
- **RAS drive:** en_call_out = btb_hit & type==10; en_ret_out = btb_hit & type==11. Both are never 1 together.
- **Update (on posedge, when upd_valid):**
  - Tag hit: rewrite target and type; ctr saturating +1 if taken, −1 if not (clamped at 00 and 11).
  - Tag miss and upd_taken: allocate; valid=1, tag, target, type written; ctr = 11 for types 01/10/11, 10 for type 00.
  - Tag miss and not taken: no change.
- **Invalidate:** inv_all clears all valid bits. It takes priority over an update in the same cycle.
- **Targets:** stored as bits [31:2]. Address arithmetic is modulo 2^32; pc 0xFFFF_FFFC gives ret_addr_out 0x0000_0000.

## Timing
- Lookup latency is 0 cycles. An update is visible to lookups from the cycle after the edge that writes it.
- Reset (rst=0, asynchronous): all valid=0, ctr=01, tag/target=0.
  - Outputs during reset: btb_hit, pred_taken, en_call_out, en_ret_out = 0.
  - pred_target = ret_addr_out = pc_in+4.
- Reset asserted mid-update: the write is lost. The entry reads invalid after release.
- Update and lookup to the same index in the same cycle: the lookup sees the old contents, unless CORE_BTB_FWD_EN is defined.
- Aliasing: a new allocation overwrites the entry at that index regardless of its prior contents.

## Configuration
- **CORE_BTB_FWD_EN defined:** when upd_valid targets the lookup index in the same cycle, the lookup sees the post-update entry (valid, tag, type, target, ctr) combinationally. inv_all still forces a miss.
- **CORE_BTB_FWD_EN undefined:** no forwarding; the lookup reads the registered state only.

## Structure
- Package core_btb_pkg:
  - type encodings BR_COND, BR_JUMP, BR_CALL, BR_RET;
  - counter constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11;
  - IDX_W derivation helper.
- Sub-module core_btb_sat_ctr: 2-bit saturating counter next-state logic (ctr, taken → ctr_next), instantiated in the update path.
- Storage: flop arrays (valid, tag, target, type, ctr), not RAM, because of the asynchronous clear.

## Test plan
- **Reset then lookup:** after reset, lookup pc 0x0000_0100 with fetch_valid → btb_hit 0, pred_target 0x0000_0104, en_call_out 0, en_ret_out 0.
- **Call allocation:** update pc 0x100, type 10, target 0x2000, taken. Next-cycle lookup 0x100 → hit, pred_taken 1, pred_target 0x2000, en_call_out 1, ret_addr_out 0x104.
- **Return via RAS:** allocate a return at pc 0x2040. Lookup with ras_addr_in 0x104 → en_ret_out 1, pred_target 0x104.
- **Counter hysteresis:**
  - Allocate cond branch pc 0x300 taken (ctr 10).
  - Two not-taken updates → pred_taken 0.
  - Two taken updates → pred_taken 1.
  - Five taken updates → ctr stays 11.
- **Alias and invalidate:**
  - Allocate 0x100, then taken branch 0x140 (same index, different tag) → lookup 0x100 misses.
  - inv_all together with upd_valid → every lookup misses next cycle.
- **Same-cycle update/lookup:** update and lookup both at 0x500, entry previously invalid. Response depends on build:
  - with CORE_BTB_FWD_EN: hit in the same cycle;
  - without CORE_BTB_FWD_EN: miss that cycle, hit the next.
